// File: rtl/cache_tag_allocator_if.sv
// cache_tag_allocator_if: bus between the cache lookup/memory side and the miss tag allocator.
// Signals: miss request (valid/ready/tag/idx), hit replacement update, flush,
//   lookup valid read, memory fetch (req/addr/ack) and tag-store write (we/way/idx/wdata/fill_done).
// master = cache side driving misses, hits and acks; slave = the allocator.
interface cache_tag_allocator_if #(
  parameter int TAG_W = 25,
  parameter int IDX_W = 5,
  parameter int OFF_W = 2
);
  logic                   miss_valid;
  logic                   miss_ready;
  logic [TAG_W-1:0]       miss_tag;
  logic [IDX_W-1:0]       miss_idx;
  logic                   hit_valid;
  logic [IDX_W-1:0]       hit_idx;
  logic [1:0]             hit_way;
  logic                   flush;
  logic [IDX_W-1:0]       lookup_idx;
  logic [3:0]             lookup_valid;
  logic                   mem_req;
  logic [TAG_W+IDX_W+OFF_W-1:0] mem_addr;
  logic                   mem_ack;
  logic                   tag_we;
  logic [1:0]             tag_way;
  logic [IDX_W-1:0]       tag_idx;
  logic [TAG_W-1:0]       tag_wdata;
  logic                   fill_done;
  modport master (
    output miss_valid, miss_tag, miss_idx, hit_valid, hit_idx, hit_way, flush, lookup_idx, mem_ack,
    input  miss_ready, lookup_valid, mem_req, mem_addr, tag_we, tag_way, tag_idx, tag_wdata, fill_done
  );
  modport slave (
    input  miss_valid, miss_tag, miss_idx, hit_valid, hit_idx, hit_way, flush, lookup_idx, mem_ack,
    output miss_ready, lookup_valid, mem_req, mem_addr, tag_we, tag_way, tag_idx, tag_wdata, fill_done
  );
endinterface

// File: rtl/cache_tag_allocator.sv
// cache_tag_allocator: miss-side victim selection, line fetch and tag fill for a 4-way cache.
// Ports: clk (rising edge), rst_n (async active-low), bus (cache_tag_allocator_if.slave):
//   miss_valid/ready/tag/idx in, hit_valid/idx/way in, flush in, lookup_idx in / lookup_valid out,
//   mem_req/mem_addr out with mem_ack in, tag_we/tag_way/tag_idx/tag_wdata/fill_done out.
// Build option CACHE_TAG_ALLOC_PLRU_EN: per-set tree pseudo-LRU replacement;
//   undefined: one global round-robin counter picks the victim of a full set.
module cache_tag_allocator #(
  parameter int TAG_W = 25,
  parameter int IDX_W = 5,
  parameter int OFF_W = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  cache_tag_allocator_if.slave bus
);
  localparam int SETS = 1 << IDX_W;
  typedef enum logic [1:0] {IDLE, VICTIM, REQ, WRITE} state_t;
  state_t               state_q, state_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [1:0]           victim_q, victim_d;
  logic [SETS-1:0][3:0] valid_q, valid_d;
  logic [3:0]           set_valid;
  logic [1:0]           policy_way;
  assign set_valid = valid_q[idx_q];
`ifdef CACHE_TAG_ALLOC_PLRU_EN
  logic [SETS-1:0][2:0] plru_q, plru_d;
  // bit0 = root, bit1 = ways 0/1, bit2 = ways 2/3; an access points the tree away from the way
  function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [1:0] w);
    plru_touch = p;
    plru_touch[0] = ~w[1];
    if (w[1]) plru_touch[2] = ~w[0];
    else plru_touch[1] = ~w[0];
  endfunction
  assign policy_way = plru_q[idx_q][0] ? {1'b1, plru_q[idx_q][2]} : {1'b0, plru_q[idx_q][1]};
  always_comb begin
    plru_d = plru_q;
    if (bus.hit_valid) plru_d[bus.hit_idx] = plru_touch(plru_q[bus.hit_idx], bus.hit_way);
    // a fill to the same set overrides a simultaneous hit
    if (state_q == WRITE) plru_d[idx_q] = plru_touch(plru_q[idx_q], victim_q);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) plru_q <= '0;
    else plru_q <= plru_d;
`else
  logic [1:0] rr_q, rr_d;
  logic       rr_used_q, rr_used_d;
  logic       unused_hit;
  assign unused_hit = ^{bus.hit_valid, bus.hit_idx, bus.hit_way};
  assign policy_way = rr_q;
  // the counter only advances when it actually supplied the victim
  assign rr_used_d = state_q == VICTIM ? &set_valid : rr_used_q;
  assign rr_d = rr_q + 2'(state_q == WRITE && rr_used_q);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rr_q <= '0;
      rr_used_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
      rr_used_q <= rr_used_d;
    end
`endif
  always_comb begin
    state_d = state_q;
    tag_d = tag_q;
    idx_d = idx_q;
    victim_d = victim_q;
    valid_d = valid_q;
    case (state_q)
      IDLE:
        if (bus.flush) valid_d = '0;
        else if (bus.miss_valid) begin
          tag_d = bus.miss_tag;
          idx_d = bus.miss_idx;
          state_d = VICTIM;
        end
      VICTIM: begin
        victim_d = !set_valid[0] ? 2'd0 : !set_valid[1] ? 2'd1 : !set_valid[2] ? 2'd2 :
                   !set_valid[3] ? 2'd3 : policy_way;
        state_d = REQ;
      end
      REQ: if (bus.mem_ack) state_d = WRITE;
      default: begin
        valid_d[idx_q][victim_q] = 1'b1;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      tag_q <= '0;
      idx_q <= '0;
      victim_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      tag_q <= tag_d;
      idx_q <= idx_d;
      victim_q <= victim_d;
      valid_q <= valid_d;
    end
  assign bus.miss_ready = state_q == IDLE && !bus.flush;
  assign bus.mem_req = state_q == REQ;
  assign bus.mem_addr = {tag_q, idx_q, {OFF_W{1'b0}}};
  assign bus.tag_we = state_q == WRITE;
  assign bus.fill_done = state_q == WRITE;
  assign bus.tag_way = victim_q;
  assign bus.tag_idx = idx_q;
  assign bus.tag_wdata = tag_q;
  assign bus.lookup_valid = valid_q[bus.lookup_idx];
endmodule
